// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S master transmitter.
package i2s_pkg;

  localparam int unsigned DefaultDataWidth = 16;
  localparam int unsigned DefaultClkDiv    = 4;
  localparam int unsigned DefaultFifoDepth = 2;

  typedef struct packed {
    logic [DefaultDataWidth-1:0] left;
    logic [DefaultDataWidth-1:0] right;
  } i2s_frame_t;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } tx_state_e;

endpackage

// File: rtl/i2s_master_tx_if.sv
// Sample stream handshake plus the I2S bus pins driven by the transmitter.
interface i2s_master_tx_if #(
  parameter int unsigned DATA_WIDTH = i2s_pkg::DefaultDataWidth
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_left;
  logic [DATA_WIDTH-1:0] s_right;
  logic                  SCK;
  logic                  WS;
  logic                  sd_out;

  modport master (
    output s_valid, s_left, s_right,
    input  s_ready, SCK, WS, sd_out
  );

  modport slave (
    input  s_valid, s_left, s_right,
    output s_ready, SCK, WS, sd_out
  );
endinterface

// File: rtl/i2s_sample_fifo.sv
// Synchronous FIFO of stereo sample pairs; pops from empty are ignored.
module i2s_sample_fifo #(
  parameter int unsigned Depth = i2s_pkg::DefaultFifoDepth,
  parameter type         T     = i2s_pkg::i2s_frame_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  T                mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/i2s_master_tx.sv
// I2S bus master transmitter: FIFO-buffered stereo pairs serialised MSB-first,
// Philips alignment (data lags WS by one SCK).
module i2s_master_tx #(
  parameter int unsigned DATA_WIDTH = i2s_pkg::DefaultDataWidth,
  parameter int unsigned CLK_DIV    = i2s_pkg::DefaultClkDiv,
  parameter int unsigned FIFO_DEPTH = i2s_pkg::DefaultFifoDepth
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  i2s_master_tx_if.slave bus,
  output logic           underrun,
  output logic           busy
);
  import i2s_pkg::*;

  localparam int unsigned FrameW = 2 * DATA_WIDTH;
  localparam int unsigned BitW   = $clog2(FrameW);
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef logic [FrameW-1:0] frame_t;

  tx_state_e       state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [BitW-1:0] bit_q, bit_d, bit_next;
  frame_t          shift_q, shift_d, fifo_rdata;
  logic            sck_q, sck_d, ws_q, ws_d, sd_q, sd_d;
  logic            underrun_q, underrun_d, ready_q;
  logic            fifo_full, fifo_empty, push, pop;
  logic            div_wrap, sck_fall;

  assign push = bus.s_valid && bus.s_ready;

  i2s_sample_fifo #(
    .Depth (FIFO_DEPTH),
    .T     (frame_t)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i ({bus.s_left, bus.s_right}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable)  state_d = StRun;
      StRun:   if (!enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign div_wrap = (div_q == DivW'(CLK_DIV - 1));
  assign sck_fall = (state_q == StRun) && div_wrap && sck_q;
  assign bit_next = (bit_q == BitW'(FrameW - 1)) ? '0 : bit_q + BitW'(1);

  always_comb begin
    div_d      = div_q;
    sck_d      = sck_q;
    ws_d       = ws_q;
    sd_d       = sd_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    underrun_d = 1'b0;
    pop        = 1'b0;
    if (!enable || (state_q == StIdle)) begin
      // Idle bus; the first enabled clk is the n=0 slot of a fresh frame.
      div_d = '0;
      sck_d = 1'b0;
      ws_d  = 1'b0;
      sd_d  = 1'b0;
      bit_d = '0;
      pop   = enable;
    end else begin
      div_d = div_wrap ? '0 : div_q + DivW'(1);
      if (div_wrap) begin
        sck_d = ~sck_q;
      end
      if (sck_fall) begin
        // After 2*DW-1 shifts the previous frame's LSB sits at the top, so n=0 needs no special case.
        bit_d   = bit_next;
        ws_d    = (bit_next >= BitW'(DATA_WIDTH));
        sd_d    = shift_q[FrameW-1];
        shift_d = shift_q << 1;
        pop     = (bit_next == '0);
      end
    end
    if (pop) begin
      shift_d    = fifo_empty ? '0 : fifo_rdata;
      underrun_d = fifo_empty;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      bit_q      <= '0;
      shift_q    <= '0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      sck_q      <= sck_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      underrun_q <= underrun_d;
      ready_q    <= 1'b1;
    end
  end

  assign bus.s_ready = ready_q && !fifo_full;
  assign bus.SCK     = sck_q;
  assign bus.WS      = ws_q;
  assign bus.sd_out  = sd_q;
  assign underrun    = underrun_q;
  assign busy        = (state_q == StRun);

endmodule

// File: tb/tb_i2s_master_tx.sv
// Bench for i2s_master_tx: two instances (DW=16/DIV=4 and DW=2/DIV=1) checked
// against a frame-queue model of the serial stream.
module tb_i2s_master_tx;
  localparam int unsigned DwA = 16;
  localparam int unsigned DivA = 4;
  localparam int unsigned DwB = 2;
  localparam int unsigned DivB = 1;
  localparam int unsigned Depth = 2;

  logic clk;
  logic reset;
  logic enable_a, enable_b;
  logic und_a, und_b, busy_a, busy_b;

  i2s_master_tx_if #(.DATA_WIDTH(DwA)) bus_a ();
  i2s_master_tx_if #(.DATA_WIDTH(DwB)) bus_b ();

  i2s_master_tx #(.DATA_WIDTH(DwA), .CLK_DIV(DivA), .FIFO_DEPTH(Depth)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable_a),
    .bus      (bus_a),
    .underrun (und_a),
    .busy     (busy_a)
  );

  i2s_master_tx #(.DATA_WIDTH(DwB), .CLK_DIV(DivB), .FIFO_DEPTH(Depth)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable_b),
    .bus      (bus_b),
    .underrun (und_b),
    .busy     (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit sel = 1'b0;
  bit stop_push = 1'b0;
  logic [31:0] exp_q[$];

  logic m_sck, m_ws, m_sd, m_und, m_busy;
  assign m_sck  = sel ? bus_b.SCK    : bus_a.SCK;
  assign m_ws   = sel ? bus_b.WS     : bus_a.WS;
  assign m_sd   = sel ? bus_b.sd_out : bus_a.sd_out;
  assign m_und  = sel ? und_b        : und_a;
  assign m_busy = sel ? busy_b       : busy_a;

  function automatic logic [31:0] frame_at(input int f);
    return (f < exp_q.size()) ? exp_q[f] : 32'h0;
  endfunction

  // Checks the stream from the clk on which enable is first seen (k=0).
  // Rise j carries slot n=j%(2DW) of frame j/(2DW); n=0 carries the previous frame's LSB.
  task automatic check_stream(input int dw, input int cdiv, input int nrises);
    int rises = 0;
    int frame_clk = 4 * dw * cdiv;
    int budget = cdiv * (2 * nrises + 2) + 8;
    logic prev_sck = 1'b0;
    logic exp_und, exp_ws, exp_sd;
    logic [31:0] fr;
    int n, f;
    for (int k = 0; k < budget && rises < nrises; k++) begin
      @(negedge clk);
      exp_und = (k % frame_clk == 0) && ((k / frame_clk) >= exp_q.size());
      n_checks++;
      if (m_und !== exp_und) begin
        n_fail++;
        $display("FAIL underrun k=%0d: got %b want %b", k, m_und, exp_und);
      end
      if (m_sck && !prev_sck) begin
        n = rises % (2 * dw);
        f = rises / (2 * dw);
        exp_ws = (n >= dw);
        if (n == 0) begin
          fr = frame_at(f - 1);
          exp_sd = (f == 0) ? 1'b0 : fr[0];
        end else begin
          fr = frame_at(f);
          exp_sd = fr[2 * dw - n];
        end
        n_checks++;
        if (k != cdiv * (2 * rises + 1) || m_ws !== exp_ws || m_sd !== exp_sd || m_busy !== 1'b1)
        begin
          n_fail++;
          $display("FAIL rise %0d: at clk %0d ws=%b sd=%b busy=%b, want clk %0d ws=%b sd=%b busy=1",
                   rises, k, m_ws, m_sd, m_busy, cdiv * (2 * rises + 1), exp_ws, exp_sd);
        end
        rises++;
      end
      prev_sck = m_sck;
    end
    n_checks++;
    if (rises != nrises) begin
      n_fail++;
      $display("FAIL rise_count: got %0d want %0d", rises, nrises);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    enable_a = 1'b0;
    enable_b = 1'b0;
    bus_a.s_valid = 1'b0;
    bus_b.s_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
  endtask

  // Call at a negedge with s_ready=1; returns at the negedge after acceptance.
  task automatic push_a(input logic [15:0] l, input logic [15:0] r);
    bus_a.s_valid = 1'b1;
    bus_a.s_left = l;
    bus_a.s_right = r;
    exp_q.push_back({l, r});
    @(negedge clk);
    bus_a.s_valid = 1'b0;
  endtask

  task automatic test_reset;
    bit found = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.SCK, bus_a.WS, bus_a.sd_out, und_a, busy_a, bus_a.s_ready,
         bus_b.SCK, bus_b.WS, bus_b.sd_out, und_b, busy_b, bus_b.s_ready} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_state: outputs not all zero in reset");
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus_a.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_at_release: got %b want 0", bus_a.s_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus_a.s_ready !== 1'b1 || bus_b.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b/%b want 1/1", bus_a.s_ready, bus_b.s_ready);
    end
    push_a(16'($urandom), 16'hFFFF);
    push_a(16'($urandom), 16'hFFFF);
    enable_a = 1'b1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      found = bus_a.SCK && bus_a.WS && bus_a.sd_out;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_setup: SCK/WS/sd_out never all high, got 0 want 1");
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.SCK, bus_a.WS, bus_a.sd_out, busy_a, und_a, bus_a.s_ready} !== 6'h0) begin
      n_fail++;
      $display("FAIL async_reset: SCK=%b WS=%b sd=%b busy=%b want all 0",
               bus_a.SCK, bus_a.WS, bus_a.sd_out, busy_a);
    end
    enable_a = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_a.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_midreset: got %b want 1", bus_a.s_ready);
    end
    enable_a = 1'b1;
    @(negedge clk);
    n_checks++;
    if (und_a !== 1'b1) begin
      n_fail++;
      $display("FAIL fifo_cleared: underrun got %b want 1", und_a);
    end
    enable_a = 1'b0;
  endtask

  task automatic test_frame;
    do_reset();
    sel = 1'b0;
    push_a(16'hA5F0, 16'h0F5A);
    push_a(16'($urandom), 16'($urandom));
    enable_a = 1'b1;
    check_stream(DwA, DivA, 97);
    enable_a = 1'b0;
  endtask

  task automatic test_underrun;
    do_reset();
    sel = 1'b0;
    enable_a = 1'b1;
    check_stream(DwA, DivA, 97);
    enable_a = 1'b0;
  endtask

  task automatic test_fifo_full;
    logic [15:0] l3, r3;
    do_reset();
    sel = 1'b0;
    push_a(16'($urandom), 16'($urandom));
    push_a(16'($urandom), 16'($urandom));
    n_checks++;
    if (bus_a.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_when_full: got %b want 0", bus_a.s_ready);
    end
    l3 = 16'($urandom);
    r3 = 16'($urandom);
    bus_a.s_valid = 1'b1;
    bus_a.s_left = l3;
    bus_a.s_right = r3;
    exp_q.push_back({l3, r3});
    enable_a = 1'b1;
    fork
      check_stream(DwA, DivA, 97);
      begin
        @(negedge clk);
        n_checks++;
        if (bus_a.s_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL ready_after_pop: got %b want 1", bus_a.s_ready);
        end
        @(negedge clk);
        bus_a.s_valid = 1'b0;
        n_checks++;
        if (bus_a.s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL third_push: ready got %b want 0", bus_a.s_ready);
        end
      end
    join
    enable_a = 1'b0;
  endtask

  task automatic test_enable_drop;
    logic [31:0] f1;
    do_reset();
    sel = 1'b0;
    push_a(16'($urandom), 16'($urandom));
    push_a(16'($urandom), 16'($urandom));
    f1 = exp_q[0];
    enable_a = 1'b1;
    check_stream(DwA, DivA, 10);
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus_a.SCK !== 1'b0 || bus_a.WS !== 1'b0 || bus_a.sd_out !== f1[22]) begin
      n_fail++;
      $display("FAIL slot_n10: SCK=%b WS=%b sd=%b want 0 0 %b",
               bus_a.SCK, bus_a.WS, bus_a.sd_out, f1[22]);
    end
    enable_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus_a.SCK, bus_a.WS, bus_a.sd_out, busy_a} !== 4'h0 || bus_a.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_drop: SCK=%b WS=%b sd=%b busy=%b ready=%b want 0 0 0 0 1",
               bus_a.SCK, bus_a.WS, bus_a.sd_out, busy_a, bus_a.s_ready);
    end
    push_a(16'($urandom), 16'($urandom));
    n_checks++;
    if (bus_a.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_kept: ready got %b want 0", bus_a.s_ready);
    end
    exp_q.delete(0);
    enable_a = 1'b1;
    check_stream(DwA, DivA, 65);
    enable_a = 1'b0;
  endtask

  task automatic test_fast;
    do_reset();
    sel = 1'b1;
    stop_push = 1'b0;
    fork
      begin
        logic [1:0] l = 2'b00;
        logic [1:0] r = 2'b00;
        bit take = 1'b1;
        while (1) begin
          @(negedge clk);
          if (stop_push) break;
          if (take) begin
            l = 2'($urandom);
            r = 2'($urandom);
          end
          bus_b.s_valid = 1'b1;
          bus_b.s_left = l;
          bus_b.s_right = r;
          take = bus_b.s_ready;
          if (take) exp_q.push_back({28'h0, l, r});
        end
        bus_b.s_valid = 1'b0;
      end
      begin
        repeat (4) @(negedge clk);
        enable_b = 1'b1;
        check_stream(DwB, DivB, 41);
        stop_push = 1'b1;
      end
    join
    enable_b = 1'b0;
    sel = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    enable_a = 1'b0;
    enable_b = 1'b0;
    bus_a.s_valid = 1'b0;
    bus_a.s_left = '0;
    bus_a.s_right = '0;
    bus_b.s_valid = 1'b0;
    bus_b.s_left = '0;
    bus_b.s_right = '0;
    test_reset();
    test_frame();
    test_underrun();
    test_fifo_full();
    test_enable_drop();
    test_fast();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
